// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the "1-then-0" mark transmitter: state encoding,
// minimum run lengths and default widths.
package seq_pattern_pkg;

  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_LEN_W = 4;

  // Two ones are needed after C so the detector walks C->A->B before the zero.
  localparam int unsigned MIN_HIGH = 2;
  localparam int unsigned MIN_LOW  = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/seq_run_counter.sv
// Load/decrement down-counter with a zero flag; times the HIGH and LOW runs.
module seq_run_counter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [LEN_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LEN_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial mark generator: on Start emits N marks of H ones followed by L zeros,
// then pulses Done for one cycle. Abort drops back to idle without Done.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [CNT_W-1:0] Num_Marks,
  input  logic [LEN_W-1:0] High_Len,
  input  logic [LEN_W-1:0] Low_Len,
  input  logic             Abort,
  output logic             Tx_Line,
  output logic             Busy,
  output logic             Done
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] n_marks, mark_cnt, mark_nxt;
  logic [LEN_W-1:0] h_run, l_run, h_clamp, l_clamp;
  logic [LEN_W-1:0] run_load_val;
  logic             run_load, run_dec, run_zero;
  logic             latch, mark_clr, mark_inc;
  logic             tx_nxt, busy_nxt, done_nxt;
  logic             tx_q, busy_q, done_q;

  assign h_clamp  = (High_Len < LEN_W'(MIN_HIGH)) ? LEN_W'(MIN_HIGH) : High_Len;
  assign l_clamp  = (Low_Len  < LEN_W'(MIN_LOW))  ? LEN_W'(MIN_LOW)  : Low_Len;
  assign mark_nxt = mark_cnt + CNT_W'(1);

  seq_run_counter #(.LEN_W(LEN_W)) u_run (
    .clk      (CLK),
    .rst      (RST),
    .load     (run_load),
    .load_val (run_load_val),
    .dec      (run_dec),
    .zero_c   (run_zero)
  );

  // State, latched parameters, mark counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      n_marks  <= '0;
      h_run    <= '0;
      l_run    <= '0;
      mark_cnt <= '0;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_q   <= tx_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (latch) begin
        n_marks <= Num_Marks;
        h_run   <= h_clamp;
        l_run   <= l_clamp;
      end
      if (mark_clr) begin
        mark_cnt <= '0;
      end else if (mark_inc) begin
        mark_cnt <= mark_nxt;
      end
    end
  end

  // Next-state, counter control and next output values.
  always_comb begin
    state_nxt    = state;
    run_load     = 1'b0;
    run_load_val = '0;
    run_dec      = 1'b0;
    latch        = 1'b0;
    mark_clr     = 1'b0;
    mark_inc     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          latch    = 1'b1;
          mark_clr = 1'b1;
          if (Num_Marks != '0) begin
            state_nxt    = ST_HIGH;
            run_load     = 1'b1;
            run_load_val = h_clamp - LEN_W'(1);
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_HIGH: begin
        if (Abort) begin
          state_nxt = ST_IDLE;
        end else if (run_zero) begin
          state_nxt    = ST_LOW;
          run_load     = 1'b1;
          run_load_val = l_run - LEN_W'(1);
        end else begin
          run_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (Abort) begin
          state_nxt = ST_IDLE;
        end else if (run_zero) begin
          mark_inc = 1'b1;
          if (mark_nxt < n_marks) begin
            state_nxt    = ST_HIGH;
            run_load     = 1'b1;
            run_load_val = h_run - LEN_W'(1);
          end else begin
            state_nxt = ST_FIN;
          end
        end else begin
          run_dec = 1'b1;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    tx_nxt   = IDLE_LVL;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_HIGH: begin tx_nxt = 1'b1; busy_nxt = 1'b1; end
      ST_LOW:  begin tx_nxt = 1'b0; busy_nxt = 1'b1; end
      ST_FIN:  done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign Tx_Line = tx_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle {Tx_Line,Busy,Done} scoreboard built from
// the mark waveform, plus a loopback A/B/C detector counting entries into C.
module tb_seq_pattern_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [7:0] Num_Marks;
  logic [3:0] High_Len;
  logic [3:0] Low_Len;
  logic       Abort;
  logic       Tx_Line;
  logic       Busy;
  logic       Done;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  logic [2:0] plan[$];
  logic [2:0] cur = 3'b000;

  seq_pattern_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Num_Marks (Num_Marks),
    .High_Len  (High_Len),
    .Low_Len   (Low_Len),
    .Abort     (Abort),
    .Tx_Line   (Tx_Line),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 CLK = ~CLK;

  // Loopback detector: A -1-> B -0-> C; C -1-> A, C -0-> A.
  localparam logic [1:0] D_A = 2'd0, D_B = 2'd1, D_C = 2'd2;
  logic [1:0] det = D_A;
  int det_c = 0;

  always @(posedge CLK) begin
    case (det)
      D_A: det <= Tx_Line ? D_B : D_A;
      D_B: if (!Tx_Line) begin det <= D_C; det_c <= det_c + 1; end
      default: det <= D_A;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected cycle stream for an accepted Start: marks of {1,busy} then {0,busy}, then Done.
  task automatic push_transfer(input int n, input int h, input int l);
    int hh = (h < 2) ? 2 : h;
    int ll = (l < 1) ? 1 : l;
    for (int m = 0; m < n; m++) begin
      for (int i = 0; i < hh; i++) plan.push_back(3'b110);
      for (int i = 0; i < ll; i++) plan.push_back(3'b010);
    end
    plan.push_back(3'b001);
  endtask

  task automatic tick(input logic st, input int n, input int h, input int l,
                      input logic ab, input logic rs);
    logic [2:0] exp;
    Start     = st;
    Num_Marks = 8'(n);
    High_Len  = 4'(h);
    Low_Len   = 4'(l);
    Abort     = ab;
    RST       = rs;
    if (rs) begin
      plan.delete();
    end else begin
      if (ab && cur[1]) plan.delete();
      if (st && !cur[1] && !cur[0]) push_transfer(n, h, l);
    end
    @(posedge CLK);
    #1;
    exp = (plan.size() > 0) ? plan.pop_front() : 3'b000;
    cur = exp;
    if (Done) done_seen++;
    check_eq("line_busy_done", 32'({Tx_Line, Busy, Done}), 32'(exp));
    Start = 1'b0;
    Abort = 1'b0;
    RST   = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  int d0, c0;

  initial begin
    Start = 1'b0; Num_Marks = '0; High_Len = '0; Low_Len = '0; Abort = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-transfer: no Done ever.
    d0 = done_seen;
    tick(1'b1, 3, 2, 2, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(15);
    check_eq("reset_no_done", 32'(done_seen - d0), 32'd0);

    // Nominal: 3 marks of 1,1,0,0,0.
    d0 = done_seen; c0 = det_c;
    tick(1'b1, 3, 2, 3, 1'b0, 1'b0);
    idle(20);
    check_eq("nominal_done", 32'(done_seen - d0), 32'd1);
    check_eq("nominal_det_c", 32'(det_c - c0), 32'd3);

    // Clamping: zero lengths become H=2, L=1.
    d0 = done_seen; c0 = det_c;
    tick(1'b1, 2, 0, 0, 1'b0, 1'b0);
    idle(10);
    check_eq("clamp_done", 32'(done_seen - d0), 32'd1);
    check_eq("clamp_det_c", 32'(det_c - c0), 32'd2);

    // Zero marks: Done next cycle, no line activity; Abort in IDLE/FIN harmless.
    d0 = done_seen;
    tick(1'b1, 0, 3, 3, 1'b1, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(3);
    check_eq("zero_done", 32'(done_seen - d0), 32'd1);

    // Abort in 2nd HIGH cycle of mark 2, restart two cycles later.
    d0 = done_seen;
    tick(1'b1, 5, 3, 3, 1'b0, 1'b0);
    idle(7);
    tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(2);
    check_eq("abort_no_done", 32'(done_seen - d0), 32'd0);
    c0 = det_c;
    tick(1'b1, 1, 2, 1, 1'b0, 1'b0);
    idle(6);
    check_eq("restart_done", 32'(done_seen - d0), 32'd1);
    check_eq("restart_det_c", 32'(det_c - c0), 32'd1);

    // Start while busy with a different N is ignored.
    d0 = done_seen; c0 = det_c;
    tick(1'b1, 2, 2, 1, 1'b0, 1'b0);
    idle(2);
    tick(1'b1, 4, 5, 5, 1'b0, 1'b0);
    idle(12);
    check_eq("ignored_done", 32'(done_seen - d0), 32'd1);
    check_eq("ignored_det_c", 32'(det_c - c0), 32'd2);

    // Start together with Abort in IDLE: Start wins.
    d0 = done_seen;
    tick(1'b1, 1, 2, 2, 1'b1, 1'b0);
    idle(6);
    check_eq("start_abort_done", 32'(done_seen - d0), 32'd1);
    check_eq("plan_drained", 32'(plan.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
